// File: rtl/reg_share_pkg.sv
// Shared types and helpers for the reg_share_arb register-sharing arbiter.
package reg_share_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Pointer width for an N-entry requester set; never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set req bit at or after start wins.
module rr_pick
  import reg_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    start,
  output logic [N_REQ-1:0] onehot,
  output logic [PW-1:0]    idx,
  output logic             any
);

  int s;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    s      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      s = int'(start) + k;
      if (s >= N_REQ) s = s - N_REQ;
      if (!any && req[s]) begin
        any       = 1'b1;
        onehot[s] = 1'b1;
        idx       = PW'(s);
      end
    end
  end

endmodule

// File: rtl/reg_share_arb.sv
// Arbiter/sequencer sharing one W-bit register between N_REQ requesters.
// Define REG_SHARE_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module reg_share_arb
  import reg_share_pkg::*;
#(
  parameter int         N_REQ   = 4,
  parameter int         W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   ack,
  output logic [W-1:0]       q,
  output logic               q_valid,
  output logic               busy
);

  // state  | meaning
  // IDLE   | waiting for any req; picks a winner when one appears
  // GRANT  | gnt high; commits if winner still requests, else withdraws
  // COMMIT | ack high for one cycle; requester drops req now

  localparam int PW = ptr_w(N_REQ);

  state_t           state;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    start;
  logic [N_REQ-1:0] pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

`ifdef REG_SHARE_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [PW-1:0] ptr;
  // Search begins just past the last winner, wrapping to index 0.
  assign start = (ptr == PW'(N_REQ - 1)) ? '0 : ptr + 1'b1;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req    (req),
    .start  (start),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      win_idx <= '0;
      gnt     <= '0;
      ack     <= '0;
      q       <= RST_VAL;
      q_valid <= 1'b0;
`ifndef REG_SHARE_FIXED_PRIO_EN
      ptr     <= PW'(N_REQ - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (pick_any) begin
            gnt     <= pick_onehot;
            win_idx <= pick_idx;
            state   <= GRANT;
          end
        end
        GRANT: begin
          gnt <= '0;
          if (req[win_idx]) begin
            q       <= wdata[int'(win_idx)*W +: W];
            q_valid <= 1'b1;
            ack     <= gnt;
`ifndef REG_SHARE_FIXED_PRIO_EN
            ptr     <= win_idx;
`endif
            state   <= COMMIT;
          end else begin
            state <= IDLE;
          end
        end
        COMMIT: begin
          ack   <= '0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          ack   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
